// File: rtl/ula_pkg.sv
// ula_pkg -- shared types for the sequential ULA core.
//
// Contents:
//   op_e     4-bit opcode encoding (values 12..15 are illegal unless the
//            optional multiplier is built, which claims 12 as OP_MUL).
//   flags_t  packed {n, v, z, c} status flags, bit 3 = N ... bit 0 = C.
//   state_e  control FSM states IDLE / SHIFT / HOLD.
//   is_shift returns 1 for the four bit-serial shift/rotate opcodes.
//
// Optional feature macro: ULA_SEQ_MUL_EN (see ula_seq_core.sv).

package ula_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_XOR = 4'd5,
    OP_ADC = 4'd6,
    OP_SBB = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ROL = 4'd10,
    OP_ROR = 4'd11,
    OP_MUL = 4'd12
  } op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Opcodes are carried as plain 4-bit vectors so illegal encodings never
  // have to be cast into the enum.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/ula_comb_core.sv
// ula_comb_core -- single-cycle combinational ALU slice.
//
// Computes ADD/SUB/AND/OR/NOT/XOR; ADC and SBB are evaluated exactly like
// ADD and SUB, the caller supplies the carry (or borrow) on cin.
// Any other opcode yields s=0, cout=0, v=0.
//
// Ports:
//   op    in   4      opcode (ula_pkg::op_e encoding)
//   a, b  in   WIDTH  operands
//   cin   in   1      carry-in (add) / borrow-in (subtract)
//   s     out  WIDTH  result
//   cout  out  1      bit WIDTH of the extended sum / difference (borrow)
//   v     out  1      signed overflow for add/subtract, 0 otherwise

module ula_comb_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             v
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  // Top bit of the extended difference is 1 exactly when a borrow occurs.
  assign diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

  always_comb begin
    s    = '0;
    cout = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        s    = sum_ext[WIDTH-1:0];
        cout = sum_ext[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        s    = diff_ext[WIDTH-1:0];
        cout = diff_ext[WIDTH];
        v    = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      OP_NOT: s = ~a;
      OP_XOR: s = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_seq_core.sv
// ula_seq_core -- handshaked, registered ALU with sticky flags, carry-chained
// ADC/SBB and bit-serial shifts/rotates.
//
// Handshake: a transfer happens on a channel in a cycle where both valid and
// ready are high at the rising clock edge. IN_READY depends only on the FSM
// state and OUT_READY (never on IN_VALID); OUT_VALID depends only on the
// state. Operands are captured only on the accepting edge.
//
// Ports:
//   CLK, RST_N    clock (rising edge), asynchronous active-low reset
//   IN_VALID/IN_READY, OP, CIN, A, B   operation input channel
//   OUT_VALID/OUT_READY, S, COUT, ERR  result output channel
//   FLAGS         sticky {N,V,Z,C}, updated on every legal result
//
// Timing: single-cycle ops and shifts by 0 show OUT_VALID one cycle after
// the accept; a shift by k>0 spends k cycles in SHIFT (one bit per cycle).
//
// Optional feature: define ULA_SEQ_MUL_EN to build an unsigned shift-add
// multiplier on opcode 12 (WIDTH iterations in SHIFT). Without it opcode 12
// is illegal like 13..15.

module ula_seq_core
  import ula_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       OP,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic [3:0]       FLAGS,
  output logic             ERR
);

  // Counter must hold WIDTH for the multiplier, not just WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  flags_t           flags_q, flags_d;

  logic             in_ready;
  logic             out_valid;
  logic             accept;

  logic             comb_cin;
  logic [WIDTH-1:0] comb_s;
  logic             comb_cout;
  logic             comb_v;

  logic [WIDTH-1:0] step;
  logic             step_out;

`ifdef ULA_SEQ_MUL_EN
  // Multiplier state: work_q holds the shrinking multiplier / growing low
  // product half, mul_hi_q the high product half, mcand_q the multiplicand.
  logic [WIDTH-1:0] mul_hi_q, mul_hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  assign mul_sum     = {1'b0, mul_hi_q} + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], work_q[WIDTH-1:1]};
`endif

  function automatic flags_t mk_flags(input logic [WIDTH-1:0] s, input logic v, input logic c);
    return '{n: s[WIDTH-1], v: v, z: (s == '0), c: c};
  endfunction

  // ADC/SBB chain on the registered carry of the previous result.
  assign comb_cin = ((OP == OP_ADC) || (OP == OP_SBB)) ? flags_q.c : CIN;

  ula_comb_core #(.WIDTH(WIDTH)) u_comb (
    .op   (OP),
    .a    (A),
    .b    (B),
    .cin  (comb_cin),
    .s    (comb_s),
    .cout (comb_cout),
    .v    (comb_v)
  );

  // One bit-serial shift step; step_out is the bit leaving the word.
  always_comb begin
    step     = work_q;
    step_out = 1'b0;
    case (op_q)
      OP_SHL: begin step = {work_q[WIDTH-2:0], 1'b0};         step_out = work_q[WIDTH-1]; end
      OP_SHR: begin step = {1'b0, work_q[WIDTH-1:1]};         step_out = work_q[0];       end
      OP_ROL: begin step = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; step_out = work_q[WIDTH-1]; end
      OP_ROR: begin step = {work_q[0], work_q[WIDTH-1:1]};    step_out = work_q[0];       end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
      flags_q  <= '0;
`ifdef ULA_SEQ_MUL_EN
      mul_hi_q <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
`ifdef ULA_SEQ_MUL_EN
      mul_hi_q <= mul_hi_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    cout_d   = cout_q;
    err_d    = err_q;
    flags_d  = flags_q;
`ifdef ULA_SEQ_MUL_EN
    mul_hi_d = mul_hi_q;
    mcand_d  = mcand_q;
`endif
    accept   = IN_VALID && in_ready;

    // Result consumed: fall back to IDLE unless a new op replaces it below.
    if ((state_q == HOLD) && OUT_READY) state_d = IDLE;

    if (state_q == SHIFT) begin
      work_d = step;
      cnt_d  = cnt_q - CNT_W'(1);
`ifdef ULA_SEQ_MUL_EN
      if (op_q == OP_MUL) begin
        work_d   = mul_lo_next;
        mul_hi_d = mul_hi_next;
      end
`endif
      if (cnt_q == CNT_W'(1)) begin
        state_d = HOLD;
        err_d   = 1'b0;
        s_d     = step;
        cout_d  = step_out;
        flags_d = mk_flags(step, 1'b0, step_out);
`ifdef ULA_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          s_d     = mul_lo_next;
          cout_d  = |mul_hi_next;
          flags_d = mk_flags(mul_lo_next, |mul_hi_next, |mul_hi_next);
        end
`endif
      end
    end

    if (accept) begin
      op_d = OP;
      if (is_shift(OP) && (B[SHAMT_W-1:0] != '0)) begin
        work_d  = A;
        cnt_d   = CNT_W'(B[SHAMT_W-1:0]);
        state_d = SHIFT;
      end
`ifdef ULA_SEQ_MUL_EN
      else if (OP == OP_MUL) begin
        work_d   = B;
        mcand_d  = A;
        mul_hi_d = '0;
        cnt_d    = CNT_W'(WIDTH);
        state_d  = SHIFT;
      end
`endif
      else if (is_shift(OP)) begin
        // Shift by zero: value passes through, nothing shifted out.
        state_d = HOLD;
        err_d   = 1'b0;
        s_d     = A;
        cout_d  = 1'b0;
        flags_d = mk_flags(A, 1'b0, 1'b0);
      end else if (OP <= OP_SBB) begin
        state_d = HOLD;
        err_d   = 1'b0;
        s_d     = comb_s;
        cout_d  = comb_cout;
        flags_d = mk_flags(comb_s, comb_v, comb_cout);
      end else begin
        // Illegal opcode: flags keep their previous value.
        state_d = HOLD;
        err_d   = 1'b1;
        s_d     = '0;
        cout_d  = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == HOLD) && OUT_READY);
    out_valid = (state_q == HOLD);
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid;
  assign S         = s_q;
  assign COUT      = cout_q;
  assign FLAGS     = flags_q;
  assign ERR       = err_q;

endmodule
